apb_req_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares the single `apbMaster` CPU-side port among `NREQ` requesters inside the APB subsystem. It latches one requester's command and drives `APBMASTERENABLE`/`CPUSEL`/`addr`/`data` to the master. It holds the command until `CPUPREADY` returns, then hands `PRDATA` back to the winner with a completion pulse. A watchdog aborts transfers that never complete.

---
 rtl/apb_req_arbiter.sv | 83 ++++++++
 tb/tb_apb_req_arbiter.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/apb_req_arbiter.sv
// apb_req_arbiter: round-robin arbiter sharing the apbMaster CPU port among NREQ requesters
module apb_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 255
) (
  input  logic                 PCLK,
  input  logic                 PRESET,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*8-1:0]    req_sel_i,
  input  logic [NREQ*8-1:0]    req_addr_i,
  input  logic [NREQ*21-1:0]   req_data_i,
  output logic [NREQ-1:0]      gnt_o,
  output logic [NREQ-1:0]      done_o,
  output logic                 err_o,
  output logic [20:0]          rdata_o,
  output logic                 APBMASTERENABLE,
  output logic [7:0]           CPUSEL,
  output logic [7:0]           addr,
  output logic [20:0]          data,
  input  logic                 CPUPREADY,
  input  logic [20:0]          PRDATA
);
  localparam int PW = $clog2(NREQ);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  state_t        state;
  logic [PW-1:0] ptr, win, nxt, idx;
  logic [7:0]    wd;
  // reverse scan so the requester closest to ptr (upward, wrapping) is the last to assign
  always_comb begin
    nxt = '0;
    idx = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (req_i[idx]) nxt = idx;
    end
  end
  always_ff @(posedge PCLK or negedge PRESET) begin
    if (!PRESET) begin
      state           <= IDLE;
      ptr             <= '0;
      win             <= '0;
      wd              <= '0;
      gnt_o           <= '0;
      done_o          <= '0;
      err_o           <= 1'b0;
      rdata_o         <= '0;
      APBMASTERENABLE <= 1'b0;
      CPUSEL          <= '0;
      addr            <= '0;
      data            <= '0;
    end else begin
      case (state)
        IDLE: if (|req_i) begin
          state           <= BUSY;
          win             <= nxt;
          wd              <= '0;
          gnt_o           <= NREQ'(1) << nxt;
          APBMASTERENABLE <= 1'b1;
          CPUSEL          <= 8'(req_sel_i >> (8 * nxt));
          addr            <= 8'(req_addr_i >> (8 * nxt));
          data            <= 21'(req_data_i >> (21 * nxt));
        end
        BUSY: if (CPUPREADY || (TIMEOUT != 0 && wd == 8'(TIMEOUT))) begin
          state           <= DONE;
          rdata_o         <= CPUPREADY ? PRDATA : '0;
          err_o           <= !CPUPREADY;
          gnt_o           <= '0;
          done_o          <= NREQ'(1) << win;
          APBMASTERENABLE <= 1'b0;
        end else begin
          wd <= wd + 8'd1;
        end
        default: begin
          state  <= IDLE;
          done_o <= '0;
          err_o  <= 1'b0;
          wd     <= '0;
          ptr    <= (int'(win) == NREQ - 1) ? '0 : win + 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_apb_req_arbiter.sv
// tb_apb_req_arbiter: directed checks of arbitration order, timeout, tie, ignore and async reset
module tb_apb_req_arbiter;
  logic        PCLK = 1'b0, PRESET = 1'b0, CPUPREADY = 1'b0, err_o, APBMASTERENABLE;
  logic [3:0]  req_i = '0, gnt_o, done_o;
  logic [31:0] req_sel_i, req_addr_i;
  logic [83:0] req_data_i;
  logic [20:0] PRDATA = '0, rdata_o, data;
  logic [7:0]  CPUSEL, addr;
  logic [7:0]  sel_tab [4] = '{8'h02, 8'h11, 8'h22, 8'h33};
  int n_tests = 0, n_fail = 0;

  apb_req_arbiter #(.NREQ(4), .TIMEOUT(4)) dut (
    .PCLK(PCLK), .PRESET(PRESET), .req_i(req_i), .req_sel_i(req_sel_i),
    .req_addr_i(req_addr_i), .req_data_i(req_data_i), .gnt_o(gnt_o), .done_o(done_o),
    .err_o(err_o), .rdata_o(rdata_o), .APBMASTERENABLE(APBMASTERENABLE), .CPUSEL(CPUSEL),
    .addr(addr), .data(data), .CPUPREADY(CPUPREADY), .PRDATA(PRDATA)
  );

  always #5 PCLK = ~PCLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge PCLK);
    #1;
  endtask

  task automatic rst_pulse;
    PRESET = 1'b0;
    #2;
    PRESET = 1'b1;
  endtask

  // one transfer with CPUPREADY in the first BUSY cycle; keep is req_i after done_o
  task automatic run(input logic [3:0] r, input int g, input logic [3:0] keep, input logic [20:0] pr);
    req_i = r;
    tick;
    chk("run_gnt", gnt_o, 32'(4'b1 << g));
    chk("run_en", APBMASTERENABLE, 1);
    chk("run_sel", CPUSEL, sel_tab[g]);
    CPUPREADY = 1'b1;
    PRDATA = pr;
    tick;
    chk("run_done", done_o, 32'(4'b1 << g));
    chk("run_rdata", rdata_o, pr);
    chk("run_err", err_o, 0);
    chk("run_en_off", APBMASTERENABLE, 0);
    CPUPREADY = 1'b0;
    req_i = keep;
    tick;
    chk("run_idle_done", done_o, 0);
  endtask

  initial begin
    req_sel_i  = {sel_tab[3], sel_tab[2], sel_tab[1], sel_tab[0]};
    req_addr_i = {8'hA3, 8'hA2, 8'hA1, 8'h10};
    req_data_i = {21'h1D003, 21'h1D002, 21'h1D001, 21'h1D000};
    #1;
    chk("rst_en", APBMASTERENABLE, 0);
    chk("rst_gnt", gnt_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_bus", {CPUSEL, addr, data[15:0]}, 0);
    #11 PRESET = 1'b1;
    // single read, CPUPREADY in the second BUSY cycle
    req_i = 4'b0001;
    tick;
    chk("t1_en", APBMASTERENABLE, 1);
    chk("t1_gnt", gnt_o, 4'b0001);
    chk("t1_sel", CPUSEL, 8'h02);
    chk("t1_addr", addr, 8'h10);
    chk("t1_data", data, 21'h1D000);
    PRDATA = 21'h1ABCD;
    tick;
    chk("t1_en2", APBMASTERENABLE, 1);
    chk("t1_done_early", done_o, 0);
    CPUPREADY = 1'b1;
    tick;
    chk("t1_done", done_o, 4'b0001);
    chk("t1_rdata", rdata_o, 21'h1ABCD);
    chk("t1_err", err_o, 0);
    chk("t1_en_off", APBMASTERENABLE, 0);
    CPUPREADY = 1'b0;
    req_i = 4'b0000;
    tick;
    chk("t1_idle_done", done_o, 0);
    chk("t1_sel_hold", CPUSEL, 8'h02);
    chk("t1_rdata_hold", rdata_o, 21'h1ABCD);
    // all four requesting from a fresh pointer
    rst_pulse;
    run(4'b1111, 0, 4'b1110, 21'h00100);
    run(4'b1110, 1, 4'b1100, 21'h00101);
    run(4'b1100, 2, 4'b1000, 21'h00102);
    run(4'b1000, 3, 4'b0000, 21'h00103);
    // fairness: after 2 wins, 0101 goes to 0, then 2
    run(4'b0100, 2, 4'b0000, 21'h00200);
    run(4'b0101, 0, 4'b0100, 21'h00201);
    run(4'b0100, 2, 4'b0000, 21'h00202);
    // timeout: pointer=3, 0010 wins, five BUSY cycles then error completion
    req_i = 4'b0010;
    tick;
    chk("to_gnt", gnt_o, 4'b0010);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("to_busy", APBMASTERENABLE, 1);
    end
    tick;
    chk("to_done", done_o, 4'b0010);
    chk("to_err", err_o, 1);
    chk("to_rdata", rdata_o, 0);
    chk("to_en_off", APBMASTERENABLE, 0);
    req_i = 4'b0000;
    tick;
    chk("to_err_clr", err_o, 0);
    run(4'b0011, 0, 4'b0000, 21'h00300);
    // tie: CPUPREADY on the timeout cycle; payload change mid-BUSY ignored
    req_i = 4'b0001;
    tick;
    chk("tie_gnt", gnt_o, 4'b0001);
    req_sel_i[7:0] = 8'hEE;
    for (int i = 0; i < 4; i++) tick;
    chk("tie_sel_kept", CPUSEL, 8'h02);
    chk("tie_busy", APBMASTERENABLE, 1);
    CPUPREADY = 1'b1;
    PRDATA = 21'h0F0F0;
    tick;
    chk("tie_done", done_o, 4'b0001);
    chk("tie_err", err_o, 0);
    chk("tie_rdata", rdata_o, 21'h0F0F0);
    CPUPREADY = 1'b0;
    req_i = 4'b0000;
    req_sel_i[7:0] = 8'h02;
    tick;
    // CPUPREADY in IDLE does nothing
    CPUPREADY = 1'b1;
    PRDATA = 21'h12345;
    tick;
    tick;
    chk("idle_rdy_done", done_o, 0);
    chk("idle_rdy_rdata", rdata_o, 21'h0F0F0);
    chk("idle_rdy_en", APBMASTERENABLE, 0);
    CPUPREADY = 1'b0;
    // asynchronous reset while BUSY
    req_i = 4'b1000;
    tick;
    chk("rb_gnt", gnt_o, 4'b1000);
    #2 PRESET = 1'b0;
    #1;
    chk("rb_en", APBMASTERENABLE, 0);
    chk("rb_gnt0", gnt_o, 0);
    chk("rb_bus", {CPUSEL, addr}, 0);
    chk("rb_data", data, 0);
    chk("rb_rdata", rdata_o, 0);
    req_i = 4'b0000;
    tick;
    chk("rb_no_done", done_o, 0);
    PRESET = 1'b1;
    tick;
    chk("rb_idle_done", done_o, 0);
    run(4'b1000, 3, 4'b0000, 21'h00400);
    run(4'b0011, 0, 4'b0000, 21'h00401);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
